bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares the single-port 8-bit image BRAM (13-bit address, 1-cycle registered read) between two requesters in the 100 MHz domain.
  - Requester 0 is the BRAM-to-FIFO streaming reader.
  - Requester 1 is the host/loader port that writes or inspects frame data.
- Round-robin arbitration with burst ownership and a bounded burst length, so neither side can starve the other.
- Routes read data back to the issuing requester, including across ownership changes.

Parameters:
- ADDR_W, 13, BRAM address width.
- DATA_W, 8, BRAM data width.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).
- MAX_BURST, 64, maximum accesses per grant when the other requester is waiting (≥2).

Ports:
- clk_100mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  requester 0 wants/holds the port; an access is issued each cycle m0_req && m0_gnt.
- m0_we  in  1  requester 0 write enable (0 = read).
- m0_addr  in  ADDR_W  requester 0 address.
- m0_din  in  DATA_W  requester 0 write data.
- m0_gnt  out  1  requester 0 owns the port this cycle.
- m0_rvalid  out  1  requester 0 read data valid.
- m0_rdata  out  DATA_W  requester 0 read data.
- m1_req, m1_we, m1_addr, m1_din, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for requester 1.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data.
- owner  out  2  00 idle, 01 requester 0, 10 requester 1.

Behaviour:
- Reset values (asynchronous, while reset_n = 0):
  - state IDLE; all gnt, rvalid, bram_en, bram_we = 0; owner = 00.
  - rdata = 0, bram_addr = 0, bram_din = 0.
  - Round-robin pointer set to favour requester 0.
  - Read-tag pipeline cleared.
  - Reset mid-burst drops all in-flight reads; no rvalid is issued for them.
- States IDLE, OWN0, OWN1. gnt_i = (state == OWNi) and is registered. owner mirrors state.
- IDLE transitions:
  - Only one req high: go to that requester's OWN state.
  - Both high: grant the requester opposite to the last owner.
  - Neither high: stay in IDLE.
  - Latency: req high in cycle N (IDLE) gives gnt high in cycle N+1, and the first access may occur in N+1.
- Access rules:
  - In OWNi, any cycle with req_i = 1 is an access. bram_en = 1, and bram_we/addr/din are driven combinationally from requester i.
  - If req_i = 0: bram_en = 0, bram_we = 0, addr/din = 0.
  - No access is ever issued in IDLE.
- Burst counter:
  - Cleared on entry to an OWN state; increments per access; saturates at MAX_BURST.
- OWNi exits to IDLE on the next edge when either:
  - req_i = 0 in the current cycle (release), or
  - this cycle's access is access number MAX_BURST and req_other = 1 (forced handover).
- With no competing request, the burst continues past MAX_BURST indefinitely.
- Handover always inserts exactly one IDLE cycle; there are no back-to-back grants to different owners.
- Read return path:
  - Every read access pushes a tag (requester id) into an RD_LAT-deep shift register.
  - After RD_LAT cycles, the tagged requester gets rvalid = 1 for one cycle, and rdata is registered from bram_dout.
  - The other requester's rvalid stays 0 and its rdata holds its last value.
  - Reads issued just before a handover are still delivered to their issuer after the grant moves.
- Write accesses produce no rvalid.
- The round-robin pointer updates to the last owner whenever leaving an OWN state.

Test Plan:
- Reset, then m0_req high with reads at addresses 0..3 → m0_gnt in cycle 1; bram_addr 0,1,2,3 on consecutive cycles; m0_rvalid pulses 4 times with RD_LAT = 1, each one cycle after its address; m1 outputs stay 0.
- m1 writes 0xA5 to 0x0100, then releases; m0 reads 0x0100 → one IDLE cycle between grants; m0_rdata = 0xA5 with m0_rvalid.
- Both req held continuously with MAX_BURST = 4 → grant pattern of 4 accesses m0, IDLE, 4 accesses m1, IDLE, repeating; owner toggles 01/00/10/00.
- Simultaneous first request from IDLE after reset → m0 granted first; after the m0 release and a new simultaneous request → m1 granted.
- m0 issues a read in its final (4th) burst cycle before the forced handover → m0_rvalid is still asserted in the following cycle (IDLE) with correct data; m1_rvalid stays 0.
- reset_n pulsed low mid-burst with a read in flight → all outputs 0 immediately; no rvalid after reset release; the next request is granted normally.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-port image BRAM between two requesters:
//   requester 0 : BRAM-to-FIFO streaming reader
//   requester 1 : host/loader port (writes or inspects frame data)
//
// Arbitration is round-robin with burst ownership. An owner keeps the port
// while its req stays high. When the other side is waiting, the owner is
// capped at MAX_BURST accesses. Every ownership change passes through one
// IDLE cycle. Read data is steered back to the requester that issued the
// read, even when ownership has already moved on.
//
// Handshake: while mX_gnt is high, every cycle with mX_req high is one
// access. mX_we/mX_addr/mX_din are taken combinationally in that cycle.
// Each read access produces exactly one mX_rvalid pulse RD_LAT cycles later,
// with mX_rdata valid in the same cycle. Writes produce no response.
//
// Ports
//   clk_100mhz, reset_n      : clock, asynchronous active-low reset
//   mX_req/we/addr/din       : requester X access request (X = 0, 1)
//   mX_gnt                   : requester X owns the port this cycle (registered)
//   mX_rvalid/rdata          : requester X read return
//   bram_en/we/addr/din      : BRAM command (zero whenever no access is issued)
//   bram_dout                : BRAM read data (RD_LAT-cycle registered read)
//   owner                    : 00 idle, 01 requester 0, 10 requester 1 (FSM state)
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 64
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,

    output logic [1:0]        owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Encoding equals the owner output code, so owner is the state register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_burst;       // accesses performed in the current grant
    logic                r_last_own1;   // 1: requester 1 owned last (favours 0)
    logic [RD_LAT-1:0]   r_tag_v;       // read-tag pipeline: valid
    logic [RD_LAT-1:0]   r_tag_id;      // read-tag pipeline: issuing requester
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_acc0;
    logic                w_acc1;
    logic                w_access;
    logic                w_burst_done;
    logic                w_ret_v;
    logic                w_ret_id;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_acc0   = (r_state == ST_OWN0) && m0_req;
    assign w_acc1   = (r_state == ST_OWN1) && m1_req;
    assign w_access = w_acc0 || w_acc1;

    // This cycle's access is number MAX_BURST (or later, once saturated).
    assign w_burst_done = (r_burst >= CNT_W'(MAX_BURST - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    w_next = r_last_own1 ? ST_OWN0 : ST_OWN1;
                end else if (m0_req) begin
                    w_next = ST_OWN0;
                end else if (m1_req) begin
                    w_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_req || (m1_req && w_burst_done)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!m1_req || (m0_req && w_burst_done)) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign owner  = r_state;
    assign m0_gnt = (r_state == ST_OWN0);
    assign m1_gnt = (r_state == ST_OWN1);

    // ------------------------------------------------------------------
    // BRAM command mux: all-zero when no access is issued.
    // ------------------------------------------------------------------
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (w_acc0) begin
            bram_en   = 1'b1;
            bram_we   = m0_we;
            bram_addr = m0_addr;
            bram_din  = m0_din;
        end else if (w_acc1) begin
            bram_en   = 1'b1;
            bram_we   = m1_we;
            bram_addr = m1_addr;
            bram_din  = m1_din;
        end
    end

    // ------------------------------------------------------------------
    // Burst counter and round-robin pointer.
    // OWN states are only entered from IDLE, so holding the counter at
    // zero in IDLE is the same as clearing it on entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_burst     <= '0;
            r_last_own1 <= 1'b1;
        end else begin
            if (r_state == ST_IDLE) begin
                r_burst <= '0;
            end else if (w_access && (r_burst != CNT_W'(MAX_BURST))) begin
                r_burst <= r_burst + 1'b1;
            end

            if ((r_state != ST_IDLE) && (w_next == ST_IDLE)) begin
                r_last_own1 <= (r_state == ST_OWN1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-tag pipeline: one stage per cycle of BRAM read latency. The tag
    // travels independently of the grant, so reads issued just before a
    // handover still return to their issuer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_access && !bram_we;
            r_tag_id[0] <= w_acc1;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign w_ret_v   = r_tag_v[RD_LAT-1];
    assign w_ret_id  = r_tag_id[RD_LAT-1];
    assign m0_rvalid = w_ret_v && !w_ret_id;
    assign m1_rvalid = w_ret_v &&  w_ret_id;

    // ------------------------------------------------------------------
    // Read data. bram_dout comes straight from the BRAM output register and
    // is presented in the rvalid cycle; a per-requester hold register keeps
    // the last returned word afterwards, so the non-addressed requester's
    // rdata never changes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (m0_rvalid) begin
                r_m0_rdata <= bram_dout;
            end
            if (m1_rvalid) begin
                r_m1_rdata <= bram_dout;
            end
        end
    end

    assign m0_rdata = m0_rvalid ? bram_dout : r_m0_rdata;
    assign m1_rdata = m1_rvalid ? bram_dout : r_m1_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Drives directed access sequences into bram_port_arbiter connected to a
// behavioural single-port BRAM. A transaction-level reference (who owns the
// port, how many accesses the grant has made, a shadow memory and a queue
// of outstanding reads with their due cycle) predicts every output each
// cycle; a few literal expectations pin the reference itself.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int MAXB = 4;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          m0_req  = 1'b0;
    logic          m0_we   = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_din  = '0;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req  = 1'b0;
    logic          m1_we   = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_din  = '0;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic [1:0]    owner;

    bram_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RD_LAT   (LAT),
        .MAX_BURST(MAXB)
    ) dut (
        .clk_100mhz(clk),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_din    (m0_din),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_din    (m1_din),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .owner     (owner)
    );

    // ---------------- behavioural BRAM (1-cycle registered read) ----------------
    logic [DW-1:0] tb_mem  [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            tb_mem[i]  = DW'(i) ^ 8'h5A;
            ref_mem[i] = DW'(i) ^ 8'h5A;
        end
    end

    initial forever begin
        @(posedge clk);
        if (bram_en) begin
            if (bram_we) tb_mem[bram_addr] = bram_din;
            else         bram_dout <= tb_mem[bram_addr];
        end
    end

    // ---------------- counters / check helper ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rd_q[$];
    int            m_own  = -1;   // -1 idle, else requester id
    int            m_last = 1;    // last owner; 1 makes requester 0 win first
    int            m_cnt  = 0;    // accesses made under the current grant
    int            m_cyc  = 0;
    logic [DW-1:0] m_hold [2];
    logic [AW-1:0] m_a;
    rd_t           m_e;

    function automatic logic req_of(input int p);
        return (p == 0) ? m0_req : m1_req;
    endfunction
    function automatic logic we_of(input int p);
        return (p == 0) ? m0_we : m1_we;
    endfunction
    function automatic logic [AW-1:0] addr_of(input int p);
        return (p == 0) ? m0_addr : m1_addr;
    endfunction
    function automatic logic [DW-1:0] din_of(input int p);
        return (p == 0) ? m0_din : m1_din;
    endfunction
    function automatic logic gnt_of(input int p);
        return (p == 0) ? m0_gnt : m1_gnt;
    endfunction

    initial begin
        m_hold[0] = '0;
        m_hold[1] = '0;
    end

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_own = -1; m_last = 1; m_cnt = 0;
            rd_q.delete();
            m_hold[0] = '0; m_hold[1] = '0;
        end else begin
            if (rd_q.size() > 0 && rd_q[0].due == m_cyc) begin
                m_hold[rd_q[0].id] = rd_q[0].data;
                void'(rd_q.pop_front());
            end
            if (m_own >= 0 && req_of(m_own)) begin
                m_a = addr_of(m_own);
                if (we_of(m_own)) begin
                    ref_mem[m_a] = din_of(m_own);
                end else begin
                    m_e.due  = m_cyc + LAT;
                    m_e.id   = m_own;
                    m_e.data = ref_mem[m_a];
                    rd_q.push_back(m_e);
                end
                m_cnt++;
            end
            if (m_own < 0) begin
                m_cnt = 0;
                if (m0_req && m1_req) m_own = 1 - m_last;
                else if (m0_req)      m_own = 0;
                else if (m1_req)      m_own = 1;
            end else if (!req_of(m_own) || (req_of(1 - m_own) && m_cnt >= MAXB)) begin
                m_last = m_own;
                m_own  = -1;
            end
            m_cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic          e_acc;
    logic          e_dlv;
    logic [1:0]    e_own;
    logic [1:0]    e_rv;
    logic [DW-1:0] e_rd [2];

    initial forever begin
        @(negedge clk);
        e_acc = (m_own >= 0) && req_of(m_own);
        e_dlv = (rd_q.size() > 0) && (rd_q[0].due == m_cyc);
        e_own = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
        for (int p = 0; p < 2; p++) begin
            e_rv[p] = e_dlv && (rd_q[0].id == p);
            e_rd[p] = e_rv[p] ? rd_q[0].data : m_hold[p];
        end
        chk("m0_gnt",    m0_gnt,    m_own == 0);
        chk("m1_gnt",    m1_gnt,    m_own == 1);
        chk("owner",     owner,     e_own);
        chk("bram_en",   bram_en,   e_acc);
        chk("bram_we",   bram_we,   e_acc ? we_of(m_own) : 1'b0);
        chk("bram_addr", bram_addr, e_acc ? addr_of(m_own) : '0);
        chk("bram_din",  bram_din,  e_acc ? din_of(m_own) : '0);
        chk("m0_rvalid", m0_rvalid, e_rv[0]);
        chk("m1_rvalid", m1_rvalid, e_rv[1]);
        chk("m0_rdata",  m0_rdata,  e_rd[0]);
        chk("m1_rdata",  m1_rdata,  e_rd[1]);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds one access on requester p until it is granted and consumed.
    task automatic do_access(input int p, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        int w;
        w = 0;
        if (p == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_din = d; end
        else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_din = d; end
        while (!gnt_of(p) && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL access_timeout: requester %0d got no grant after %0d cycles, required within 50", p, w);
        end
        tick();
    endtask

    task automatic rel(input int p);
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        @(negedge clk);
        chk("rst_gnt0",   m0_gnt,   1'b0);
        chk("rst_owner",  owner,    2'b00);
        chk("rst_en",     bram_en,  1'b0);
        chk("rst_rdata0", m0_rdata, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: stimulus did not complete within 100000 ns");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] lit_d   [4];
    logic [1:0]    exp_own [15];
    logic [1:0]    rec_own [15];
    logic          rv0_5, rv1_5;
    logic [DW-1:0] rd0_5;

    initial begin
        lit_d   = '{8'h5A, 8'h5B, 8'h58, 8'h59};
        exp_own = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2,
                    2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

        // --- Test 1: m0 reads 0..3 straight after reset ---
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) m0_addr = AW'(i);
            else       m0_req  = 1'b0;
            @(negedge clk);
            if (i == 0) chk("t1_gnt_cycle1", m0_gnt, 1'b1);
            if (i < 4)  chk("t1_addr", bram_addr, AW'(i));
            if (i > 0) begin
                chk("t1_rvalid", m0_rvalid, 1'b1);
                chk("t1_rdata",  m0_rdata,  lit_d[i-1]);
            end
            chk("t1_m1_rvalid", m1_rvalid, 1'b0);
            tick();
        end
        repeat (2) tick();

        // --- Test 2: m1 writes A5 to 0x100, m0 reads it back ---
        do_access(1, 1'b1, 13'h0100, 8'hA5);
        rel(1);
        do_access(0, 1'b0, 13'h0100, 8'h00);
        rel(0);
        @(negedge clk);
        chk("t2_rvalid",    m0_rvalid, 1'b1);
        chk("t2_rdata",     m0_rdata,  8'hA5);
        chk("t2_m1_rvalid", m1_rvalid, 1'b0);
        tick();
        repeat (2) tick();

        // --- Test 3: both requesters saturate, bursts of MAXB alternate ---
        do_reset();
        fork
            begin
                for (int k = 0; k < 8; k++) do_access(0, 1'b0, AW'(16 + k), 8'h00);
                rel(0);
            end
            begin
                for (int k = 0; k < 8; k++) do_access(1, 1'b0, AW'(32 + k), 8'h00);
                rel(1);
            end
            begin
                for (int k = 0; k < 15; k++) begin
                    @(negedge clk);
                    rec_own[k] = owner;
                    if (k == 5) begin
                        rv0_5 = m0_rvalid;
                        rv1_5 = m1_rvalid;
                        rd0_5 = m0_rdata;
                    end
                end
            end
        join
        for (int k = 0; k < 15; k++) chk("t3_owner_seq", rec_own[k], exp_own[k]);
        chk("t3_tail_rvalid0", rv0_5, 1'b1);
        chk("t3_tail_rvalid1", rv1_5, 1'b0);
        chk("t3_tail_rdata0",  rd0_5, 8'h49);
        repeat (3) tick();

        // --- Test 4: simultaneous requests alternate between owners ---
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = 13'd7; m1_addr = 13'd8;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_first_gnt0", m0_gnt, 1'b1);
        chk("t4_first_gnt1", m1_gnt, 1'b0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_second_gnt1", m1_gnt, 1'b1);
        chk("t4_second_gnt0", m0_gnt, 1'b0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        // --- Test 6: reset mid-burst with a read in flight ---
        do_access(0, 1'b0, 13'd5, 8'h00);
        do_access(0, 1'b0, 13'd6, 8'h00);
        reset_n = 1'b0;
        m0_req  = 1'b0;
        @(negedge clk);
        chk("t6_gnt0",   m0_gnt,    1'b0);
        chk("t6_rvalid", m0_rvalid, 1'b0);
        chk("t6_en",     bram_en,   1'b0);
        chk("t6_owner",  owner,     2'b00);
        chk("t6_rdata",  m0_rdata,  8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_rvalid0", m0_rvalid, 1'b0);
            chk("t6_no_rvalid1", m1_rvalid, 1'b0);
            tick();
        end
        do_access(1, 1'b0, 13'h0100, 8'h00);
        rel(1);
        @(negedge clk);
        chk("t6_after_rvalid", m1_rvalid, 1'b1);
        chk("t6_after_rdata",  m1_rdata,  8'hA5);
        tick();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
